// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit -- operand forwarding, load-use interlock, redirect squash and data-memory wait freeze
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   id_rs1/2, id_use_rs1/2        ID-stage sources and their use flags
//   ex_rd/regwrite/wdsel          EX-stage destination (wdsel 01 = load)
//   mem_rd/regwrite, wb_rd/regwrite  MEM/WB destinations for forwarding
//   mem_redirect                  non-sequential PC chosen in MEM
//   dm_req, dm_ready              data-memory handshake in MEM
//   *_en, *_flush                 stage-register load enables and bubble inserts
//   fwd_a, fwd_b                  ALU operand source select (00 RF, 01 EX/MEM, 10 MEM/WB)
//   state                         0 = RUN, 1 = MEM_WAIT
//   stall_cnt, flush_cnt          saturating performance counters
//   mem_timeout                   sticky watchdog for over-long memory waits
module hazard_ctrl #(
    parameter int CNT_W    = 16,
    parameter int WAIT_MAX = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_regwrite,
    input  logic [1:0]       ex_wdsel,
    input  logic [4:0]       mem_rd,
    input  logic             mem_regwrite,
    input  logic [4:0]       wb_rd,
    input  logic             wb_regwrite,
    input  logic             mem_redirect,
    input  logic             dm_req,
    input  logic             dm_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout
);
    typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;
    // wait counter only needs to reach WAIT_MAX+1, where it parks
    localparam int WW = $clog2(WAIT_MAX + 2);
    localparam logic [WW-1:0] WLIM = WW'(WAIT_MAX + 1);
    state_t           r_state;
    logic [WW-1:0]    r_wait;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             r_timeout;
    logic             w_mstall;
    logic             w_lu;
    logic             w_redir;
    logic             w_lu_act;
    logic [WW-1:0]    w_wait_nxt;
    assign w_mstall = (r_state == RUN) ? (dm_req & ~dm_ready) : ~dm_ready;
    assign w_lu = ex_regwrite & (ex_wdsel == 2'b01) & (ex_rd != 5'd0) &
                  ((id_use_rs1 & (ex_rd == id_rs1)) | (id_use_rs2 & (ex_rd == id_rs2)));
    // redirect outranks load-use: the load-using instruction is squashed anyway
    assign w_redir    = ~w_mstall & mem_redirect;
    assign w_lu_act   = ~w_mstall & ~mem_redirect & w_lu;
    assign w_wait_nxt = (r_wait == WLIM) ? WLIM : r_wait + 1'b1;
    always_comb begin
        pc_en       = ~rst & ~w_mstall & ~w_lu_act;
        ifid_en     = ~rst & ~w_mstall & ~w_lu_act;
        idex_en     = ~rst & ~w_mstall;
        exmem_en    = ~rst & ~w_mstall;
        memwb_en    = ~rst & ~w_mstall;
        ifid_flush  = rst | w_redir;
        idex_flush  = rst | w_redir | w_lu_act;
        exmem_flush = rst | w_redir;
        // forwarding ignores stalls; the nearer stage (EX/MEM) wins
        fwd_a = rst ? 2'b00 :
                (mem_regwrite && mem_rd != 5'd0 && mem_rd == id_rs1) ? 2'b01 :
                (wb_regwrite && wb_rd != 5'd0 && wb_rd == id_rs1) ? 2'b10 : 2'b00;
        fwd_b = rst ? 2'b00 :
                (mem_regwrite && mem_rd != 5'd0 && mem_rd == id_rs2) ? 2'b01 :
                (wb_regwrite && wb_rd != 5'd0 && wb_rd == id_rs2) ? 2'b10 : 2'b00;
        state = rst ? 1'b0 : r_state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RUN;
            r_wait      <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            if ((w_mstall || w_lu_act) && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_redir && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 1'b1;
            if (r_state == RUN && dm_req && !dm_ready) begin
                r_state <= MEM_WAIT;
                r_wait  <= '0;
            end else if (r_state == MEM_WAIT && dm_ready) begin
                r_state <= RUN;
            end else if (r_state == MEM_WAIT) begin
                r_wait <= w_wait_nxt;
                if (w_wait_nxt == WLIM) r_timeout <= 1'b1;
            end
        end
    end
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;
    assign mem_timeout = r_timeout;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed stimulus with a cycle-level reference model and hand-computed spot checks
module tb_hazard_ctrl;
    localparam int CNT_W    = 4;
    localparam int WAIT_MAX = 4;
    localparam int CMAX     = (1 << CNT_W) - 1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
    logic id_use_rs1, id_use_rs2, ex_regwrite, mem_regwrite, wb_regwrite, mem_redirect, dm_req, dm_ready;
    logic [1:0] ex_wdsel, fwd_a, fwd_b;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush, state, mem_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [4:0] en;
    logic [2:0] fl;
    int n_vec = 0;
    int n_err = 0;
    assign en = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
    assign fl = {ifid_flush, idex_flush, exmem_flush};

    hazard_ctrl #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_wdsel(ex_wdsel),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .mem_redirect(mem_redirect), .dm_req(dm_req), .dm_ready(dm_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    // reference model: cycle class 0 normal, 1 memory stall, 2 redirect, 3 load-use, 4 reset
    logic [4:0] en_tab [5] = '{5'b11111, 5'b00000, 5'b11111, 5'b00111, 5'b00000};
    logic [2:0] fl_tab [5] = '{3'b000, 3'b000, 3'b111, 3'b010, 3'b111};
    int m_wait = 0, m_wcnt = 0, m_to = 0, m_stall = 0, m_flush = 0, m_known = 0, cls = 0;
    logic mstall, lu;

    function automatic logic [1:0] mfwd(input logic [4:0] rs);
        if (mem_regwrite && mem_rd != 0 && mem_rd == rs) return 2'b01;
        if (wb_regwrite && wb_rd != 0 && wb_rd == rs) return 2'b10;
        return 2'b00;
    endfunction

    initial forever begin
        @(negedge clk);
        mstall = (m_wait != 0) ? !dm_ready : (dm_req && !dm_ready);
        lu = ex_regwrite && ex_wdsel == 2'b01 && ex_rd != 0 &&
             ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
        cls = rst ? 4 : mstall ? 1 : mem_redirect ? 2 : lu ? 3 : 0;
        chk("m enables", 32'(en), 32'(en_tab[cls]));
        chk("m flushes", 32'(fl), 32'(fl_tab[cls]));
        chk("m fwd", 32'({fwd_a, fwd_b}), rst ? 32'd0 : 32'({mfwd(id_rs1), mfwd(id_rs2)}));
        chk("m state", 32'(state), rst ? 32'd0 : 32'(m_wait));
        if (m_known != 0) begin
            chk("m stall_cnt", 32'(stall_cnt), 32'(m_stall));
            chk("m flush_cnt", 32'(flush_cnt), 32'(m_flush));
            chk("m mem_timeout", 32'(mem_timeout), 32'(m_to));
        end
        @(posedge clk);
        if (rst) begin
            m_wait = 0; m_wcnt = 0; m_to = 0; m_stall = 0; m_flush = 0; m_known = 1;
        end else begin
            if ((cls == 1 || cls == 3) && m_stall < CMAX) m_stall++;
            if (cls == 2 && m_flush < CMAX) m_flush++;
            if (m_wait == 0) begin
                if (dm_req && !dm_ready) begin m_wait = 1; m_wcnt = 0; end
            end else if (dm_ready) begin
                m_wait = 0;
            end else begin
                m_wcnt++;
                if (m_wcnt > WAIT_MAX) m_to = 1;
            end
        end
    end

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_rd = 0; ex_regwrite = 0; ex_wdsel = 0;
        mem_rd = 0; mem_regwrite = 0; wb_rd = 0; wb_regwrite = 0;
        mem_redirect = 0; dm_req = 0; dm_ready = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        tick(); rst = 1; idle();
        tick(); rst = 0;
    endtask

    initial begin
        idle(); rst = 1;
        mem_rd = 7; mem_regwrite = 1; id_rs1 = 7;
        tick(); tick(); #2;
        chk("rst en", 32'(en), 0); chk("rst fl", 32'(fl), 32'b111); chk("rst fwd_a", 32'(fwd_a), 0);
        chk("rst state", 32'(state), 0); chk("rst stall_cnt", 32'(stall_cnt), 0); chk("rst timeout", 32'(mem_timeout), 0);
        // load-use
        tick(); rst = 0; idle();
        ex_wdsel = 2'b01; ex_rd = 5; ex_regwrite = 1; id_rs1 = 5; id_use_rs1 = 1; #2;
        chk("lu pc_en", 32'(pc_en), 0); chk("lu ifid_en", 32'(ifid_en), 0);
        chk("lu idex_flush", 32'(idex_flush), 1); chk("lu idex_en", 32'(idex_en), 1);
        tick(); idle(); #2;
        chk("lu stall_cnt", 32'(stall_cnt), 1); chk("lu pc_en after", 32'(pc_en), 1); chk("lu idex_flush after", 32'(idex_flush), 0);
        tick(); ex_wdsel = 2'b01; ex_rd = 5; ex_regwrite = 1; id_rs1 = 5; id_use_rs1 = 0; #2;
        chk("lu unused src", 32'(pc_en), 1);
        // forwarding
        tick(); idle(); mem_rd = 7; wb_rd = 7; mem_regwrite = 1; wb_regwrite = 1; id_rs2 = 7; id_rs1 = 3; #2;
        chk("fwd_b mem", 32'(fwd_b), 32'b01); chk("fwd_a none", 32'(fwd_a), 0);
        tick(); mem_regwrite = 0; #2;
        chk("fwd_b wb", 32'(fwd_b), 32'b10);
        tick(); mem_rd = 0; wb_rd = 0; mem_regwrite = 1; wb_regwrite = 1; id_rs1 = 0; id_rs2 = 0; #2;
        chk("fwd_a x0", 32'(fwd_a), 0); chk("fwd_b x0", 32'(fwd_b), 0);
        // memory wait of 3 stall cycles
        rst_pulse();
        dm_req = 1; mem_rd = 9; mem_regwrite = 1; id_rs1 = 9; #2;
        chk("mw c1 en", 32'(en), 0); chk("mw c1 state", 32'(state), 0); chk("mw fwd_a", 32'(fwd_a), 32'b01);
        tick(); #2;
        chk("mw c2 en", 32'(en), 0); chk("mw c2 state", 32'(state), 1);
        tick(); #2;
        chk("mw c3 en", 32'(en), 0); chk("mw c3 state", 32'(state), 1);
        tick(); dm_ready = 1; #2;
        chk("mw rel en", 32'(en), 32'b11111);
        tick(); dm_req = 0; dm_ready = 0; #2;
        chk("mw after state", 32'(state), 0); chk("mw stall_cnt", 32'(stall_cnt), 3);
        tick(); dm_req = 1; dm_ready = 1; #2;
        chk("req+ready en", 32'(en), 32'b11111);
        tick(); dm_req = 0; dm_ready = 0; #2;
        chk("req+ready state", 32'(state), 0); chk("req+ready stall_cnt", 32'(stall_cnt), 3);
        // redirect pending across a 2-cycle wait
        rst_pulse();
        dm_req = 1; mem_redirect = 1; #2;
        chk("rw c1 fl", 32'(fl), 0);
        tick(); #2;
        chk("rw c2 fl", 32'(fl), 0); chk("rw c2 state", 32'(state), 1);
        tick(); dm_ready = 1; #2;
        chk("rw rel fl", 32'(fl), 32'b111); chk("rw rel en", 32'(en), 32'b11111);
        tick(); idle(); #2;
        chk("rw flush_cnt", 32'(flush_cnt), 1); chk("rw stall_cnt", 32'(stall_cnt), 2);
        // redirect outranks load-use
        rst_pulse();
        mem_redirect = 1; ex_wdsel = 2'b01; ex_rd = 3; ex_regwrite = 1; id_rs2 = 3; id_use_rs2 = 1; #2;
        chk("rd>lu fl", 32'(fl), 32'b111); chk("rd>lu en", 32'(en), 32'b11111);
        tick(); idle(); #2;
        chk("rd>lu flush_cnt", 32'(flush_cnt), 1); chk("rd>lu stall_cnt", 32'(stall_cnt), 0);
        // 5-cycle wait stays under the watchdog
        rst_pulse();
        dm_req = 1;
        repeat (5) tick();
        dm_ready = 1; #2;
        tick(); idle(); #2;
        chk("wd5 timeout", 32'(mem_timeout), 0);
        // 6-cycle wait trips it
        rst_pulse();
        dm_req = 1;
        repeat (5) tick();
        #2 chk("wd6 c6 timeout", 32'(mem_timeout), 0);
        tick(); dm_ready = 1; #2;
        chk("wd6 rel timeout", 32'(mem_timeout), 1);
        tick(); idle(); #2;
        chk("wd6 sticky", 32'(mem_timeout), 1);
        tick(); rst = 1; #2;
        tick(); #2;
        chk("wd6 rst clears", 32'(mem_timeout), 0);
        // reset in the middle of a wait
        tick(); rst = 0; idle(); dm_req = 1;
        tick(); tick(); #2;
        chk("rmw state wait", 32'(state), 1);
        tick(); rst = 1; #2;
        tick(); #2;
        chk("rmw state", 32'(state), 0); chk("rmw stall_cnt", 32'(stall_cnt), 0);
        chk("rmw flush_cnt", 32'(flush_cnt), 0); chk("rmw fl", 32'(fl), 32'b111);
        tick(); rst = 0; idle(); #2;
        chk("rmw run", 32'(state), 0); chk("rmw en", 32'(en), 32'b11111);
        // stall counter saturation
        rst_pulse();
        ex_wdsel = 2'b01; ex_rd = 4; ex_regwrite = 1; id_rs1 = 4; id_use_rs1 = 1;
        repeat (20) tick();
        #2 chk("sat stall_cnt", 32'(stall_cnt), 15);
        tick(); idle();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
